fetch_queue: RTL and testbench

Parametrised instruction-fetch front end replacing the bare PC register and pc+4 adder of the five-stage core. It owns the fetch PC and keeps a DEPTH-entry prefetch FIFO of {pc, instr} pairs between instruction memory and ID. It adds a valid/ready stall interface towards ID and a back-pressure input from instruction memory. An EX-stage redirect flushes all queued wrong-path instructions in one cycle.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 84 ++++++++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end.
//   XLEN          default address/data width
//   NOP           canonical RV32 no-op (addi x0, x0, 0)
//   fetch_entry_t one prefetch FIFO entry: {pc, instr}
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Circular prefetch buffer: synchronous write, combinational read of the head.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset of pointers
//   push         write wr_data at the tail (ignored while clear)
//   pop          retire the head entry (ignored while clear)
//   clear        empty the buffer in one cycle; wins over push/pop
//   wr_data      entry to write
//   rd_data      head entry (storage[rd_ptr]); undefined content when empty
//   count        number of valid entries, 0..DEPTH
//   full, empty  count == DEPTH / count == 0
// The caller must not push when full without popping in the same cycle.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign do_push = push & ~clear;
    assign do_pop  = pop  & ~clear;

    // Storage is data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr_reg] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = storage[rd_ptr_reg];
    assign count   = count_reg;
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);

endmodule : fetch_fifo

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end: owns the fetch PC and buffers {pc, instr} pairs
// from instruction memory in a DEPTH-entry prefetch FIFO towards ID.
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   imem_addr     fetch address, straight from the fetch_pc register
//   imem_ready    imem_data is valid for imem_addr this cycle
//   imem_data     instruction returned by instruction memory
//   redirect      EX taken branch/jump: flush queue and refetch from target
//   redirect_pc   redirect target, low two bits forced to zero
//   id_ready      ID consumes the head entry this cycle
//   if_valid      head entry present
//   if_instr      head instruction (0 when !if_valid)
//   if_pc         head PC (0 when !if_valid)
//   if_pc_plus4   if_pc + 4 (0 when !if_valid)
// All if_* outputs depend only on registered state.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);

    localparam int WIDTH = XLEN + 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc_reg;
    logic [XLEN-1:0]  fetch_pc_next;

    logic [WIDTH-1:0] head_entry;
    logic [XLEN-1:0]  head_pc;
    logic [31:0]      head_instr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    logic             pop;
    logic             push;

    // Redirect targets are word aligned; the low bits are dropped on purpose.
    logic             unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc[1:0];

    assign if_valid = (fifo_count != '0);

    // A redirect squashes both the head handoff and the in-flight fetch.
    assign pop  = if_valid & id_ready & ~redirect;
    // Filling the slot freed by a same-cycle pop keeps a full queue streaming.
    assign push = imem_ready & ~redirect & (~fifo_full | pop);

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (redirect) begin
            fetch_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            fetch_pc_next = fetch_pc_reg + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    fetch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .clear   (redirect),
        .wr_data ({fetch_pc_reg, imem_data}),
        .rd_data (head_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_pc    = head_entry[WIDTH-1:32];
    assign head_instr = head_entry[31:0];

    assign imem_addr   = fetch_pc_reg;
    // Storage is not reset, so the head must be masked while the queue is empty.
    assign if_instr    = fifo_empty ? '0 : head_instr;
    assign if_pc       = fifo_empty ? '0 : head_pc;
    assign if_pc_plus4 = fifo_empty ? '0 : head_pc + XLEN'(4);

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] SIG      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int vectors = 0;
    int miscompares = 0;

    fetch_entry_t sb[$];
    logic [31:0]  m_pc;

    always #5 clk = ~clk;

    // Instruction memory: returns a signature of the address it was given.
    assign imem_data = imem_addr ^ SIG;

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard head and the model fetch PC.
    task automatic check_outputs(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, sb.size() != 0});
        if (sb.size() != 0) begin
            chk({tag, ".if_pc"}, if_pc, sb[0].pc);
            chk({tag, ".if_instr"}, if_instr, sb[0].instr);
            chk({tag, ".if_pc_plus4"}, if_pc_plus4, sb[0].pc + 32'd4);
        end else begin
            chk({tag, ".if_pc"}, if_pc, 32'h0);
            chk({tag, ".if_instr"}, if_instr, 32'h0);
            chk({tag, ".if_pc_plus4"}, if_pc_plus4, 32'h0);
        end
    endtask

    // One clock cycle: drive inputs, check current outputs, advance the model.
    task automatic cycle(input string tag, input logic idr, input logic imr,
                         input logic rd, input logic [31:0] rpc);
        fetch_entry_t e;
        logic         p_pop;
        logic         p_push;
        id_ready    = idr;
        imem_ready  = imr;
        redirect    = rd;
        redirect_pc = rpc;
        #0;
        check_outputs(tag);
        if (rd) begin
            sb.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            p_pop  = (sb.size() != 0) && idr;
            p_push = imr && ((sb.size() < DEPTH) || p_pop);
            if (p_pop) void'(sb.pop_front());
            if (p_push) begin
                e.pc    = m_pc;
                e.instr = m_pc ^ SIG;
                sb.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        $display("[%0t] %s id_ready=%0b imem_ready=%0b redirect=%0b if_valid=%0b if_pc=%h imem_addr=%h",
                 $time, tag, idr, imr, rd, if_valid, if_pc, imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        m_pc = RESET_PC;
    endtask

    // Reset pulse starting mid-cycle and released mid-cycle after one edge.
    task automatic do_reset();
        id_ready   = 1'b0;
        imem_ready = 1'b0;
        redirect   = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] exp_pc;
        m_pc = RESET_PC;

        // Reset state while reset is held.
        #2;
        chk("rst.if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst.imem_addr", imem_addr, RESET_PC);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // 1: stream from reset release.
        cycle("t1.c0", 1'b1, 1'b1, 1'b0, '0);
        chk("t1.pc0", if_pc, 32'h0);
        cycle("t1.c1", 1'b1, 1'b1, 1'b0, '0);
        chk("t1.pc1", if_pc, 32'h4);
        chk("t1.plus4", if_pc_plus4, 32'h8);
        cycle("t1.c2", 1'b1, 1'b1, 1'b0, '0);
        chk("t1.pc2", if_pc, 32'h8);
        chk("t1.count", 32'(dut.fifo_count), 32'd1);

        // 2: ID stall fills the queue, then drains without gaps.
        do_reset();
        for (int i = 0; i < 6; i++) cycle("t2.stall", 1'b0, 1'b1, 1'b0, '0);
        chk("t2.count", 32'(dut.fifo_count), 32'd4);
        chk("t2.addr", imem_addr, 32'h10);
        for (int i = 0; i < 5; i++) begin
            exp_pc = 32'(i * 4);
            chk("t2.drain_pc", if_pc, exp_pc);
            cycle("t2.drain", 1'b1, 1'b1, 1'b0, '0);
        end

        // 3: redirect with three queued entries.
        do_reset();
        for (int i = 0; i < 3; i++) cycle("t3.fill", 1'b0, 1'b1, 1'b0, '0);
        chk("t3.count", 32'(dut.fifo_count), 32'd3);
        cycle("t3.redir", 1'b1, 1'b1, 1'b1, 32'h0000_1002);
        chk("t3.valid", {31'b0, if_valid}, 32'h0);
        chk("t3.addr", imem_addr, 32'h1000);
        cycle("t3.c1", 1'b1, 1'b1, 1'b0, '0);
        chk("t3.pc", if_pc, 32'h1000);
        cycle("t3.c2", 1'b1, 1'b1, 1'b0, '0);
        chk("t3.pc_next", if_pc, 32'h1004);

        // 4: imem_ready toggling leaves bubbles.
        do_reset();
        cycle("t4.r1", 1'b1, 1'b1, 1'b0, '0);
        chk("t4.pc0", if_pc, 32'h0);
        cycle("t4.r0", 1'b1, 1'b0, 1'b0, '0);
        chk("t4.bubble0", {31'b0, if_valid}, 32'h0);
        cycle("t4.r1b", 1'b1, 1'b1, 1'b0, '0);
        chk("t4.pc1", if_pc, 32'h4);
        cycle("t4.r0b", 1'b1, 1'b0, 1'b0, '0);
        chk("t4.bubble1", {31'b0, if_valid}, 32'h0);

        // 5: full queue with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 4; i++) cycle("t5.fill", 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            chk("t5.count", 32'(dut.fifo_count), 32'd4);
            exp_pc = 32'(i * 4);
            chk("t5.pc", if_pc, exp_pc);
            cycle("t5.pp", 1'b1, 1'b1, 1'b0, '0);
        end

        // 6: asynchronous reset during a redirect.
        cycle("t6.a", 1'b0, 1'b1, 1'b0, '0);
        id_ready    = 1'b1;
        imem_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2000;
        #2 reset = 1'b1;
        #1;
        chk("t6.valid", {31'b0, if_valid}, 32'h0);
        chk("t6.pc", if_pc, 32'h0);
        chk("t6.instr", if_instr, 32'h0);
        chk("t6.plus4", if_pc_plus4, 32'h0);
        chk("t6.addr", imem_addr, RESET_PC);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        reset    = 1'b0;
        model_reset();
        cycle("t6.c0", 1'b1, 1'b1, 1'b0, '0);
        chk("t6.resume", if_pc, RESET_PC);
        cycle("t6.c1", 1'b1, 1'b1, 1'b0, '0);

        // 7: randomised mix against the scoreboard.
        for (int i = 0; i < 60; i++) begin
            cycle("t7.rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) == 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fetch_queue
